// File: rtl/iso15693_reader_tx_seq_if.sv
// Byte stream from the SSP deframer into the ISO 15693 reader transmit sequencer.
interface iso15693_reader_tx_seq_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, output byte_last, input byte_ready);
    modport slave  (input byte_data, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/iso15693_reader_tx_seq.sv
// ISO 15693 reader->tag frame sequencer, 1-out-of-4 coding: SOF, data symbols, EOF.
// mod_out = 1 means carrier off.
//
// state | meaning
// IDLE  | no frame; holding register may still be prefetched
// SOF   | 8 half-slots, pattern 1,0,0,0,0,1,0,0
// DATA  | 4 symbols per byte, 8 half-slots each, LSB pair first
// EOF   | 4 half-slots, pattern 0,0,1,0
module iso15693_reader_tx_seq #(
    parameter int HALF_SLOT = 128
) (
    input  logic ck_1356meg,
    input  logic rst_n,
    input  logic tx_start,
    input  logic tx_abort,
    iso15693_reader_tx_seq_if.slave byte_if,
    output logic mod_out,
    output logic busy,
    output logic done,
    output logic underrun
);
    localparam int CW = $clog2(HALF_SLOT);

    typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [2:0]    h;
    logic [1:0]    sym;
    logic [7:0]    shift;
    logic          last_r;
    logic          hold_full;
    logic          hold_last;
    logic [7:0]    hold_data;

    logic slot_end;
    logic load;

    assign byte_if.byte_ready = ~hold_full;
    assign slot_end = (cyc == CW'(HALF_SLOT - 1));
    assign load     = byte_if.byte_valid & ~hold_full;

    function automatic logic sof_bit(input logic [2:0] hs);
        return (hs == 3'd0) || (hs == 3'd5);
    endfunction

    function automatic logic data_bit(input logic [2:0] hs, input logic [1:0] v);
        return hs == {v, 1'b1};
    endfunction

    function automatic logic eof_bit(input logic [2:0] hs);
        return hs == 3'd2;
    endfunction

    // mod_out is always loaded with the value of the half-slot being entered.
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc       <= '0;
            h         <= '0;
            sym       <= '0;
            shift     <= '0;
            last_r    <= 1'b0;
            hold_full <= 1'b0;
            hold_last <= 1'b0;
            hold_data <= '0;
            mod_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            if (load) begin
                hold_full <= 1'b1;
                hold_data <= byte_if.byte_data;
                hold_last <= byte_if.byte_last;
            end
            if (tx_abort) begin
                state     <= IDLE;
                mod_out   <= 1'b0;
                busy      <= 1'b0;
                hold_full <= 1'b0;
                cyc       <= '0;
                h         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        mod_out <= 1'b0;
                        if (tx_start) begin
                            state   <= SOF;
                            busy    <= 1'b1;
                            cyc     <= '0;
                            h       <= '0;
                            mod_out <= sof_bit(3'd0);
                        end
                    end
                    SOF: begin
                        if (!slot_end) begin
                            cyc <= cyc + CW'(1);
                        end else begin
                            cyc <= '0;
                            if (h == 3'd7) begin
                                h <= '0;
                                if (hold_full) begin
                                    state     <= DATA;
                                    shift     <= hold_data;
                                    last_r    <= hold_last;
                                    hold_full <= 1'b0;
                                    sym       <= '0;
                                    mod_out   <= data_bit(3'd0, hold_data[1:0]);
                                end else begin
                                    state    <= IDLE;
                                    underrun <= 1'b1;
                                    busy     <= 1'b0;
                                    mod_out  <= 1'b0;
                                end
                            end else begin
                                h       <= h + 3'd1;
                                mod_out <= sof_bit(h + 3'd1);
                            end
                        end
                    end
                    DATA: begin
                        if (!slot_end) begin
                            cyc <= cyc + CW'(1);
                        end else begin
                            cyc <= '0;
                            if (h != 3'd7) begin
                                h       <= h + 3'd1;
                                mod_out <= data_bit(h + 3'd1, shift[1:0]);
                            end else begin
                                h <= '0;
                                if (sym != 2'd3) begin
                                    sym     <= sym + 2'd1;
                                    shift   <= shift >> 2;
                                    mod_out <= data_bit(3'd0, shift[3:2]);
                                end else if (last_r) begin
                                    state   <= EOF;
                                    mod_out <= eof_bit(3'd0);
                                end else if (hold_full) begin
                                    shift     <= hold_data;
                                    last_r    <= hold_last;
                                    hold_full <= 1'b0;
                                    sym       <= '0;
                                    mod_out   <= data_bit(3'd0, hold_data[1:0]);
                                end else begin
                                    state    <= IDLE;
                                    underrun <= 1'b1;
                                    busy     <= 1'b0;
                                    mod_out  <= 1'b0;
                                end
                            end
                        end
                    end
                    EOF: begin
                        if (!slot_end) begin
                            cyc <= cyc + CW'(1);
                        end else begin
                            cyc <= '0;
                            if (h == 3'd3) begin
                                state   <= IDLE;
                                h       <= '0;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                mod_out <= 1'b0;
                            end else begin
                                h       <= h + 3'd1;
                                mod_out <= eof_bit(h + 3'd1);
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        mod_out <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iso15693_reader_tx_seq.sv
// Bench for iso15693_reader_tx_seq: expected half-slot modulation queued per frame, checked cycle by cycle.
module tb_iso15693_reader_tx_seq;
    localparam int HS = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_start = 1'b0;
    logic tx_abort = 1'b0;
    logic mod_out, busy, done, underrun;

    iso15693_reader_tx_seq_if bif ();

    iso15693_reader_tx_seq #(.HALF_SLOT(HS)) dut (
        .ck_1356meg(clk),
        .rst_n     (rst_n),
        .tx_start  (tx_start),
        .tx_abort  (tx_abort),
        .byte_if   (bif),
        .mod_out   (mod_out),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // kind: 0 = ends with done, 1 = ends with underrun, 2 = aborted at len
    typedef struct {
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        int         feed_delay;
        int         len;
        int         kind;
    } vec_t;

    vec_t vecs[6];
    bit   exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_prints = 0;
    int   restart_j = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int cnt = 0;
        @(negedge clk);
        bif.byte_data  = b;
        bif.byte_last  = l;
        bif.byte_valid = 1'b1;
        while (bif.byte_ready !== 1'b1 && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20000) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_handshake: byte_ready never rose, expected a transfer");
        end
        @(negedge clk);
        bif.byte_valid = 1'b0;
    endtask

    task automatic push_sof();
        bit pat [8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        foreach (pat[i]) exp_q.push_back(pat[i]);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            int v;
            v = int'(b[2*i +: 2]);
            for (int hs = 0; hs < 8; hs++) exp_q.push_back(hs == 2*v + 1);
        end
    endtask

    task automatic push_eof();
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Called at the negedge just after the edge that accepted tx_start (j = 0).
    task automatic monitor(input int len, input int kind);
        bit cur = 1'b0;
        bit bad = 1'b0;
        bit ok;
        for (int j = 0; j < len; j++) begin
            if (j % HS == 0) begin
                bad = 1'b0;
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else begin
                    cur = 1'b0;
                    bad = 1'b1;
                end
            end
            if (mod_out !== cur || busy !== 1'b1 || done !== 1'b0 || underrun !== 1'b0) bad = 1'b1;
            if (j % HS == HS - 1) begin
                n_tests++;
                if (bad) begin
                    n_fail++;
                    if (n_prints < 20)
                        $display("FAIL half_slot_%0d: mod_out=%b busy=%b done=%b underrun=%b, expected mod_out=%b busy=1 done=0 underrun=0",
                                 j / HS, mod_out, busy, done, underrun, cur);
                    n_prints++;
                end
            end
            tx_start = (j + 1 == restart_j);
            tx_abort = (kind == 2 && j + 1 == len);
            @(negedge clk);
        end
        tx_start = 1'b0;
        tx_abort = 1'b0;
        case (kind)
            0: begin
                check("done_pulse", done, 1);
                check("busy_after_eof", busy, 0);
                check("mod_after_eof", mod_out, 0);
                check("scoreboard_drain", exp_q.size(), 0);
                @(negedge clk);
                check("done_one_cycle", done, 0);
            end
            1: begin
                check("underrun_pulse", underrun, 1);
                check("underrun_no_done", done, 0);
                check("underrun_busy", busy, 0);
                check("underrun_mod", mod_out, 0);
                check("scoreboard_drain", exp_q.size(), 0);
                @(negedge clk);
                check("underrun_one_cycle", underrun, 0);
                check("underrun_ready", bif.byte_ready, 1);
            end
            default: begin
                check("abort_mod", mod_out, 0);
                check("abort_busy", busy, 0);
                check("abort_ready", bif.byte_ready, 1);
                check("abort_no_done", done, 0);
                check("abort_no_underrun", underrun, 0);
                exp_q.delete();
                ok = 1'b1;
                repeat (200) begin
                    @(negedge clk);
                    if (done !== 1'b0 || mod_out !== 1'b0 || busy !== 1'b0) ok = 1'b0;
                end
                check("abort_stays_idle", ok, 1);
            end
        endcase
    endtask

    task automatic run_vec(input vec_t v);
        exp_q.delete();
        push_sof();
        if (v.nb >= 1) push_byte(v.b0);
        if (v.nb == 2) push_byte(v.b1);
        if (v.kind == 0) push_eof();
        if (v.nb >= 1) send_byte(v.b0, v.nb == 1 && v.kind == 0);
        check("prefetch_ready", bif.byte_ready, (v.nb >= 1) ? 0 : 1);
        start_frame();
        fork
            monitor(v.len, v.kind);
            begin
                if (v.nb == 2) begin
                    repeat (v.feed_delay) @(negedge clk);
                    send_byte(v.b1, v.kind == 0);
                end
            end
        join
    endtask

    initial begin
        bit ok;
        vec_t va;
        vecs[0] = '{1, 8'h00, 8'h00, 0,    5632, 0};
        vecs[1] = '{1, 8'hE4, 8'h00, 0,    5632, 0};
        vecs[2] = '{2, 8'h5A, 8'hA5, 2500, 9728, 0};
        vecs[3] = '{2, 8'hFF, 8'h81, 0,    9728, 0};
        vecs[4] = '{1, 8'h3C, 8'h00, 0,    5120, 1};
        vecs[5] = '{0, 8'h00, 8'h00, 0,    1024, 1};
        bif.byte_data  = 8'h00;
        bif.byte_last  = 1'b0;
        bif.byte_valid = 1'b0;

        #12;
        check("reset_mod", mod_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_underrun", underrun, 0);
        check("reset_ready", bif.byte_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            repeat (5) @(negedge clk);
        end

        // Abort in the 2nd data symbol with a second byte waiting; a tx_start while busy is ignored.
        va = '{2, 8'h12, 8'h34, 1500, 2548, 2};
        restart_j = 300;
        run_vec(va);
        restart_j = -1;

        // tx_start together with tx_abort in IDLE: abort wins and the prefetched byte is dropped.
        send_byte(8'h77, 1'b1);
        @(negedge clk);
        tx_start = 1'b1;
        tx_abort = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_abort = 1'b0;
        check("coinc_busy", busy, 0);
        check("coinc_ready", bif.byte_ready, 1);
        ok = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || mod_out !== 1'b0) ok = 1'b0;
        end
        check("coinc_no_frame", ok, 1);

        // Async reset while SOF half-slot 5 drives mod_out high.
        send_byte(8'hC9, 1'b1);
        start_frame();
        repeat (640) @(negedge clk);
        check("sof_h5_high", mod_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mod", mod_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", bif.byte_ready, 1);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        va = '{1, 8'hC9, 8'h00, 0, 5632, 0};
        run_vec(va);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
